// File: rtl/hilo_sched.sv
// ---------------------------------------------------------------------------
// hilo_sched
//
// Multi-cycle HI/LO scheduler for a MIPS-style pipeline. An E-stage mult,
// multu, div or divu computes its 64-bit result as soon as it is issued and
// parks it in res_hi/res_lo. The architectural HI/LO registers only take the
// new value once a fixed busy window (MULT_CYC or DIV_CYC cycles) has run
// out, which models the latency of an iterative multiplier/divider. While
// that window is open the D-stage is stalled if it holds any instruction
// touching HI/LO.
//
// Parameters
//   MULT_CYC    busy cycles for mult/multu (1..15)
//   DIV_CYC     busy cycles for div/divu   (1..15)
//
// Ports
//   clk         single clock, all state updates on the rising edge
//   reset       asynchronous, active-low reset
//   E_start     one-cycle issue strobe for a mult/div in E
//   E_op        00 mult, 01 multu, 10 div, 11 divu
//   E_A, E_B    forwarded rs / rt operands in E
//   E_mthi      write E_A into HI (only while idle and not starting)
//   E_mtlo      write E_A into LO (only while idle and not starting)
//   D_hilo_use  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
//   stall_D     freeze PC and F/D, insert a bubble into D/E
//   busy        an operation is in progress (includes the done cycle)
//   done        one-cycle pulse in the cycle HI/LO first show the result
//   HI, LO      architectural HI/LO, registered
// ---------------------------------------------------------------------------
module hilo_sched #(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        E_start,
   input  logic [1:0]  E_op,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        E_mthi,
   input  logic        E_mtlo,
   input  logic        D_hilo_use,
   output logic        stall_D,
   output logic        busy,
   output logic        done,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [3:0] MULT_CNT = 4'(MULT_CYC);
   localparam logic [3:0] DIV_CNT  = 4'(DIV_CYC);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state;
   logic [3:0]  cnt;
   logic [31:0] res_hi;
   logic [31:0] res_lo;

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic        signed_div;
   logic        a_neg;
   logic        b_neg;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] q_mag;
   logic [31:0] r_mag;
   logic [31:0] div_q;
   logic [31:0] div_r;
   logic [31:0] calc_hi;
   logic [31:0] calc_lo;
   logic [3:0]  load_cnt;
   logic        idle_free;
   logic        accept;
   logic        move_ok;

   // Result datapath. Signed division is done on magnitudes and the signs
   // are re-applied afterwards: the quotient is negative when exactly one
   // operand is, the remainder follows the dividend. Working on magnitudes
   // also makes 0x80000000 / -1 fall out naturally as quotient 0x80000000,
   // remainder 0, without a separate overflow case. A zero divisor is
   // forced to HI = dividend, LO = all ones.
   always_comb begin
      prod_s     = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
      prod_u     = {32'd0, E_A} * {32'd0, E_B};
      signed_div = ~E_op[0];
      a_neg      = signed_div & E_A[31];
      b_neg      = signed_div & E_B[31];
      a_mag      = a_neg ? (32'd0 - E_A) : E_A;
      b_mag      = b_neg ? (32'd0 - E_B) : E_B;
      q_mag      = 32'd0;
      r_mag      = 32'd0;
      if (b_mag != 32'd0) begin
         q_mag = a_mag / b_mag;
         r_mag = a_mag % b_mag;
      end
      div_q      = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      div_r      = a_neg ? (32'd0 - r_mag) : r_mag;
      calc_hi    = 32'd0;
      calc_lo    = 32'd0;
      if (!E_op[1]) begin
         if (E_op[0]) begin
            calc_hi = prod_u[63:32];
            calc_lo = prod_u[31:0];
         end else begin
            calc_hi = prod_s[63:32];
            calc_lo = prod_s[31:0];
         end
      end else if (E_B == 32'd0) begin
         calc_hi = E_A;
         calc_lo = 32'hFFFF_FFFF;
      end else begin
         calc_hi = div_r;
         calc_lo = div_q;
      end
      load_cnt   = E_op[1] ? DIV_CNT : MULT_CNT;
   end

   // The unit is free only when the FSM is idle and the done cycle has
   // also passed; busy still covers the done cycle, so a start or move
   // arriving there is ignored just like one arriving mid-operation.
   // A start always beats a simultaneous mthi/mtlo.
   always_comb begin
      idle_free = (state == IDLE) & ~busy;
      accept    = idle_free & E_start;
      move_ok   = idle_free & ~E_start;
   end

   // Any HI/LO instruction in D must wait while an operation is in flight
   // or is being issued right now from E.
   assign stall_D = D_hilo_use & (busy | E_start);

   // Scheduler FSM. The result is captured at issue time and cnt counts the
   // busy window down; on the edge where cnt steps down to 1 the result is
   // committed to HI/LO together with the done pulse, so HI/LO and done
   // appear in the N-th cycle after the issue edge. A one-cycle latency
   // commits straight from IDLE on the issue edge. busy is cleared one
   // edge after done so it spans the done cycle as well.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         res_hi <= 32'd0;
         res_lo <= 32'd0;
         HI     <= 32'd0;
         LO     <= 32'd0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (busy) begin
                  busy <= 1'b0;
               end else if (accept) begin
                  res_hi <= calc_hi;
                  res_lo <= calc_lo;
                  busy   <= 1'b1;
                  if (load_cnt <= 4'd1) begin
                     cnt  <= 4'd0;
                     HI   <= calc_hi;
                     LO   <= calc_lo;
                     done <= 1'b1;
                  end else begin
                     cnt   <= load_cnt;
                     state <= BUSY;
                  end
               end else if (move_ok) begin
                  if (E_mthi) begin
                     HI <= E_A;
                  end
                  if (E_mtlo) begin
                     LO <= E_A;
                  end
               end
            end
            BUSY: begin
               cnt <= cnt - 4'd1;
               if (cnt <= 4'd2) begin
                  HI    <= res_hi;
                  LO    <= res_lo;
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hilo_sched.sv
// ---------------------------------------------------------------------------
// tb_hilo_sched
//
// Self-checking bench for hilo_sched. Stimulus pushes the expected HI/LO
// result and the cycle it must appear in onto a scoreboard queue; an
// independent monitor on the falling edge pops an entry whenever the DUT
// raises done and checks busy, done, stall_D and HI/LO every cycle against
// a cycle-window model. Results come from 64-bit integer arithmetic.
// ---------------------------------------------------------------------------
module tb_hilo_sched;

   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        E_start;
   logic [1:0]  E_op;
   logic [31:0] E_A;
   logic [31:0] E_B;
   logic        E_mthi;
   logic        E_mtlo;
   logic        D_hilo_use;
   logic        stall_D;
   logic        busy;
   logic        done;
   logic [31:0] HI;
   logic [31:0] LO;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          due;
   } exp_t;

   exp_t        sbQ[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          busyStart = 1;
   int          busyEnd = 0;
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;

   hilo_sched #(
      .MULT_CYC(MULT_N),
      .DIV_CYC (DIV_N)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .E_start   (E_start),
      .E_op      (E_op),
      .E_A       (E_A),
      .E_B       (E_B),
      .E_mthi    (E_mthi),
      .E_mtlo    (E_mtlo),
      .D_hilo_use(D_hilo_use),
      .stall_D   (stall_D),
      .busy      (busy),
      .done      (done),
      .HI        (HI),
      .LO        (LO)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Edge counter used as the time base of the reference windows.
   always @(posedge clk) cyc <= cyc + 1;

   // Reference arithmetic in 64-bit integers: products are exact, and
   // quotient/remainder use the language's truncating division, which
   // cannot overflow at this width.
   function automatic void refCompute(input logic [1:0] op, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] hi,
                                      output logic [31:0] lo);
      longint x;
      longint y;
      longint p;
      longint q;
      longint r;
      if (op[0]) begin
         x = longint'(a);
         y = longint'(b);
      end else begin
         x = longint'($signed(a));
         y = longint'($signed(b));
      end
      if (!op[1]) begin
         p  = x * y;
         hi = p[63:32];
         lo = p[31:0];
      end else if (b == 32'd0) begin
         hi = a;
         lo = 32'hFFFF_FFFF;
      end else begin
         q  = x / y;
         r  = x % y;
         hi = r[31:0];
         lo = q[31:0];
      end
   endfunction

   // One comparison: counts it and reports a failure line when it differs.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s actual=%h expected=%h cycle=%0d", name, act, want, cyc);
      end
   endtask

   // Drives one E-stage cycle (issue and/or move) starting just after a
   // rising edge, records the expectation, and returns just after the next
   // rising edge with the strobes cleared.
   task automatic applyStimulus(input logic start, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic mthi, input logic mtlo);
      exp_t        e;
      logic [31:0] h;
      logic [31:0] l;
      int          n;
      E_start = start;
      E_op    = op;
      E_A     = a;
      E_B     = b;
      E_mthi  = mthi;
      E_mtlo  = mtlo;
      if (start) begin
         n = op[1] ? DIV_N : MULT_N;
         refCompute(op, a, b, h, l);
         e.hi  = h;
         e.lo  = l;
         e.due = cyc + n;
         sbQ.push_back(e);
         busyStart = cyc + 1;
         busyEnd   = cyc + n;
      end
      @(posedge clk);
      #1;
      if (!start) begin
         if (mthi) modelHi = a;
         if (mtlo) modelLo = a;
      end
      E_start = 1'b0;
      E_mthi  = 1'b0;
      E_mtlo  = 1'b0;
   endtask

   // Advances to the first cycle after the expected done cycle.
   task automatic waitIdle();
      while (cyc <= busyEnd) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Monitor: each falling edge out of reset, compare the handshake outputs
   // to the expected busy window and pop the scoreboard when done is seen.
   exp_t monE;
   logic monBusy;
   logic monDone;
   always @(negedge clk) begin
      if (reset) begin
         monBusy = (cyc >= busyStart) && (cyc <= busyEnd);
         monDone = (cyc == busyEnd);
         checkOutput("busy", 32'(busy), 32'(monBusy));
         checkOutput("done", 32'(done), 32'(monDone));
         checkOutput("stall_D", 32'(stall_D), 32'(D_hilo_use & (monBusy | E_start)));
         if (done) begin
            if (sbQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL done_unexpected actual=1 expected=0 cycle=%0d", cyc);
            end else begin
               monE = sbQ.pop_front();
               checkOutput("done_cycle", 32'(cyc), 32'(monE.due));
               modelHi = monE.hi;
               modelLo = monE.lo;
            end
         end
         checkOutput("HI", HI, modelHi);
         checkOutput("LO", LO, modelLo);
      end
   end

   // Watchdog so the run always ends even if something stalls forever.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main sequence: reset checks, directed cases, mid-op reset, random mix.
   initial begin
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;
      reset      = 1'b0;
      E_start    = 1'b0;
      E_op       = 2'b00;
      E_A        = 32'd0;
      E_B        = 32'd0;
      E_mthi     = 1'b0;
      E_mtlo     = 1'b0;
      D_hilo_use = 1'b1;
      #1;
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_HI", HI, 32'd0);
      checkOutput("rst_LO", LO, 32'd0);
      checkOutput("rst_stall_idle", 32'(stall_D), 32'd0);
      E_start = 1'b1;
      #1;
      checkOutput("rst_stall_start", 32'(stall_D), 32'd1);
      E_start    = 1'b0;
      D_hilo_use = 1'b0;
      idleCycles(2);
      reset = 1'b1;

      // Signed mult issued on the first edge after reset release.
      applyStimulus(1'b1, 2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
      waitIdle();
      checkOutput("mult_neg_HI", HI, 32'hFFFF_FFFF);
      checkOutput("mult_neg_LO", LO, 32'hFFFF_FFFA);

      // divu with a HI/LO user held in D for the whole operation.
      D_hilo_use = 1'b1;
      applyStimulus(1'b1, 2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
      waitIdle();
      checkOutput("divu_LO", LO, 32'd14);
      checkOutput("divu_HI", HI, 32'd2);
      checkOutput("divu_stall_after", 32'(stall_D), 32'd0);
      D_hilo_use = 1'b0;

      applyStimulus(1'b1, 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
      waitIdle();
      checkOutput("div_neg_LO", LO, 32'hFFFF_FFFD);
      checkOutput("div_neg_HI", HI, 32'hFFFF_FFFF);

      applyStimulus(1'b1, 2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
      waitIdle();
      checkOutput("div_zero_HI", HI, 32'd5);
      checkOutput("div_zero_LO", LO, 32'hFFFF_FFFF);

      applyStimulus(1'b1, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
      waitIdle();
      checkOutput("div_ovf_LO", LO, 32'h8000_0000);
      checkOutput("div_ovf_HI", HI, 32'd0);

      // Moves: plain mthi, then mtlo colliding with a start.
      applyStimulus(1'b0, 2'b00, 32'h0000_1234, 32'd0, 1'b1, 1'b0);
      checkOutput("mthi_HI", HI, 32'h0000_1234);
      applyStimulus(1'b1, 2'b00, 32'd6, 32'd7, 1'b0, 1'b1);
      waitIdle();
      checkOutput("mtlo_drop_LO", LO, 32'd42);

      // multu of all-ones followed directly by another issue.
      applyStimulus(1'b1, 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
      waitIdle();
      checkOutput("multu_HI", HI, 32'hFFFF_FFFE);
      checkOutput("multu_LO", LO, 32'd1);
      applyStimulus(1'b1, 2'b00, 32'd3, 32'd4, 1'b0, 1'b0);
      waitIdle();
      checkOutput("b2b_LO", LO, 32'd12);

      // Reset in the middle of a div: everything clears, no done later.
      applyStimulus(1'b1, 2'b10, 32'd1000, 32'd3, 1'b0, 1'b0);
      idleCycles(2);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      checkOutput("midrst_done", 32'(done), 32'd0);
      checkOutput("midrst_HI", HI, 32'd0);
      checkOutput("midrst_LO", LO, 32'd0);
      sbQ.delete();
      busyStart = 1;
      busyEnd   = 0;
      modelHi   = 32'd0;
      modelLo   = 32'd0;
      idleCycles(2);
      reset = 1'b1;
      idleCycles(DIV_N + 2);

      // Randomized mix of operations and moves.
      for (int i = 0; i < 40; i++) begin
         D_hilo_use = 1'($urandom_range(0, 1));
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0: rb = 32'($urandom_range(0, 9));
            1: rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 3) == 0) begin
            applyStimulus(1'b0, rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus(1'b1, rop, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            waitIdle();
         end
         idleCycles(int'($urandom_range(0, 2)));
      end

      idleCycles(2);
      checkOutput("sb_empty", 32'(sbQ.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
